// File: rtl/mac_pkg.sv
// Shared types and constants for the INT8 dot-product sequencer.
package mac_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        HOLD  = 3'd4
    } state_t;

    localparam int DRAIN_CYCLES   = 2;
    localparam int MAC_PIPE_DEPTH = 2;
    localparam int INT8_MIN       = -128;
    localparam int INT8_MAX       = 127;

endpackage

// File: rtl/mac_requant.sv
// Combinational requantizer: arithmetic shift with round-half-up, optional ReLU,
// then saturation to a signed DATA_WIDTH value.
module mac_requant
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32
) (
    input  logic signed [ACC_WIDTH-1:0]  acc,
    input  logic        [4:0]            shift,
    input  logic                         relu,
    output logic signed [DATA_WIDTH-1:0] q
);

    localparam logic signed [ACC_WIDTH:0] Q_MAX = (ACC_WIDTH+1)'(2**(DATA_WIDTH-1) - 1);
    localparam logic signed [ACC_WIDTH:0] Q_MIN = (ACC_WIDTH+1)'(-(2**(DATA_WIDTH-1)));

    // One extra bit of headroom so the round increment cannot wrap.
    function automatic logic signed [DATA_WIDTH-1:0] requant(
        input logic signed [ACC_WIDTH-1:0] a,
        input logic        [4:0]           sh,
        input logic                        rl
    );
        logic signed [ACC_WIDTH:0] ext;
        logic signed [ACC_WIDTH:0] y;
        logic                      rnd;
        ext = (ACC_WIDTH+1)'(a);
        y   = ext >>> sh;
        rnd = (sh != 5'd0) ? a[sh - 5'd1] : 1'b0;
        y   = y + {{ACC_WIDTH{1'b0}}, rnd};
        if (rl && (y < 0))
            y = '0;
        if (y > Q_MAX)
            y = Q_MAX;
        else if (y < Q_MIN)
            y = Q_MIN;
        return DATA_WIDTH'(y);
    endfunction

    assign q = requant(acc, shift, relu);

endmodule

// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer: streams operand pairs from two SRAMs into a 2-stage MAC,
// drains it, captures the sum and hands back raw and requantized results.
module mac_seq_ctrl
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = 11
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic        [ADDR_WIDTH-1:0] cmd_act_base,
    input  logic        [ADDR_WIDTH-1:0] cmd_wgt_base,
    input  logic        [LEN_WIDTH-1:0]  cmd_len,
    input  logic        [4:0]            cmd_shift,
    input  logic                         cmd_relu,
    output logic                         act_rd_en,
    output logic        [ADDR_WIDTH-1:0] act_rd_addr,
    input  logic signed [DATA_WIDTH-1:0] act_rd_data,
    output logic                         wgt_rd_en,
    output logic        [ADDR_WIDTH-1:0] wgt_rd_addr,
    input  logic signed [DATA_WIDTH-1:0] wgt_rd_data,
    output logic signed [DATA_WIDTH-1:0] mac_a,
    output logic signed [DATA_WIDTH-1:0] mac_b,
    output logic                         mac_enable,
    output logic                         mac_accumulate,
    input  logic signed [ACC_WIDTH-1:0]  mac_result,
    input  logic                         mac_valid,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic signed [ACC_WIDTH-1:0]  res_acc,
    output logic signed [DATA_WIDTH-1:0] res_q,
    output logic                         busy
);

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   act_base_r, wgt_base_r;
    logic [LEN_WIDTH-1:0]    len_r, elem_cnt, next_idx;
    logic [4:0]              shift_r;
    logic                    relu_r;
    logic [1:0]              en_seen;
    logic                    res_valid_r;
    logic signed [ACC_WIDTH-1:0] res_acc_r;
    logic                    cmd_fire, run_last, drain_last;
    logic                    unused_mac_valid;

    assign unused_mac_valid = mac_valid;
    assign cmd_fire   = cmd_valid && (state == IDLE);
    assign next_idx   = elem_cnt + LEN_WIDTH'(1);
    assign run_last   = (elem_cnt == len_r - LEN_WIDTH'(1));
    assign drain_last = (elem_cnt == LEN_WIDTH'(DRAIN_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        cmd_ready      = 1'b0;
        busy           = 1'b1;
        act_rd_en      = 1'b0;
        wgt_rd_en      = 1'b0;
        act_rd_addr    = '0;
        wgt_rd_addr    = '0;
        mac_a          = '0;
        mac_b          = '0;
        mac_enable     = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid)
                    state_nxt = (cmd_len == '0) ? HOLD : FETCH;
            end
            FETCH: begin
                act_rd_en   = 1'b1;
                wgt_rd_en   = 1'b1;
                act_rd_addr = act_base_r;
                wgt_rd_addr = wgt_base_r;
                state_nxt   = RUN;
            end
            RUN: begin
                mac_enable = 1'b1;
                mac_a      = act_rd_data;
                mac_b      = wgt_rd_data;
                // Prefetch element i+1 so its data lands in the next RUN cycle.
                if (next_idx < len_r) begin
                    act_rd_en   = 1'b1;
                    wgt_rd_en   = 1'b1;
                    act_rd_addr = act_base_r + next_idx[ADDR_WIDTH-1:0];
                    wgt_rd_addr = wgt_base_r + next_idx[ADDR_WIDTH-1:0];
                end
                if (run_last)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                mac_enable = 1'b1;
                if (drain_last)
                    state_nxt = HOLD;
            end
            HOLD: begin
                if (res_valid_r && res_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // The first product must load, not add to whatever the MAC held before.
        mac_accumulate = mac_enable && (en_seen == 2'(MAC_PIPE_DEPTH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_base_r  <= '0;
            wgt_base_r  <= '0;
            len_r       <= '0;
            shift_r     <= '0;
            relu_r      <= 1'b0;
            elem_cnt    <= '0;
            en_seen     <= '0;
            res_valid_r <= 1'b0;
            res_acc_r   <= '0;
        end else begin
            if (cmd_fire) begin
                act_base_r <= cmd_act_base;
                wgt_base_r <= cmd_wgt_base;
                len_r      <= cmd_len;
                shift_r    <= cmd_shift;
                relu_r     <= cmd_relu;
                elem_cnt   <= '0;
                en_seen    <= '0;
            end else begin
                if (state == RUN)
                    elem_cnt <= run_last ? '0 : next_idx;
                else if (state == DRAIN)
                    elem_cnt <= next_idx;
                if (mac_enable && (en_seen != 2'(MAC_PIPE_DEPTH)))
                    en_seen <= en_seen + 2'd1;
            end
            // Result capture: sum sampled on first HOLD cycle, valid raised the next.
            if (state == HOLD) begin
                if (!res_valid_r) begin
                    res_acc_r   <= (len_r == '0) ? '0 : mac_result;
                    res_valid_r <= 1'b1;
                end else if (res_ready) begin
                    res_valid_r <= 1'b0;
                end
            end
        end
    end

    assign res_valid = res_valid_r;
    assign res_acc   = res_acc_r;

    mac_requant #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_requant (
        .acc   (res_acc_r),
        .shift (shift_r),
        .relu  (relu_r),
        .q     (res_q)
    );

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl with a behavioural 2-stage MAC and two 1-cycle SRAMs.
module tb_mac_seq_ctrl;

    localparam int DW = 8;
    localparam int AW = 32;
    localparam int RW = 10;
    localparam int LW = 11;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 cmd_valid = 1'b0;
    logic                 cmd_ready;
    logic        [RW-1:0] cmd_act_base = '0;
    logic        [RW-1:0] cmd_wgt_base = '0;
    logic        [LW-1:0] cmd_len = '0;
    logic        [4:0]    cmd_shift = '0;
    logic                 cmd_relu = 1'b0;
    logic                 act_rd_en, wgt_rd_en;
    logic        [RW-1:0] act_rd_addr, wgt_rd_addr;
    logic signed [DW-1:0] act_rd_data = '0;
    logic signed [DW-1:0] wgt_rd_data = '0;
    logic signed [DW-1:0] mac_a, mac_b;
    logic                 mac_enable, mac_accumulate;
    logic signed [AW-1:0] mac_result;
    logic                 mac_valid;
    logic                 res_valid;
    logic                 res_ready = 1'b0;
    logic signed [AW-1:0] res_acc;
    logic signed [DW-1:0] res_q;
    logic                 busy;

    mac_seq_ctrl #(
        .DATA_WIDTH (DW),
        .ACC_WIDTH  (AW),
        .ADDR_WIDTH (RW),
        .LEN_WIDTH  (LW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_act_base   (cmd_act_base),
        .cmd_wgt_base   (cmd_wgt_base),
        .cmd_len        (cmd_len),
        .cmd_shift      (cmd_shift),
        .cmd_relu       (cmd_relu),
        .act_rd_en      (act_rd_en),
        .act_rd_addr    (act_rd_addr),
        .act_rd_data    (act_rd_data),
        .wgt_rd_en      (wgt_rd_en),
        .wgt_rd_addr    (wgt_rd_addr),
        .wgt_rd_data    (wgt_rd_data),
        .mac_a          (mac_a),
        .mac_b          (mac_b),
        .mac_enable     (mac_enable),
        .mac_accumulate (mac_accumulate),
        .mac_result     (mac_result),
        .mac_valid      (mac_valid),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_acc        (res_acc),
        .res_q          (res_q),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // SRAM models
    logic signed [DW-1:0] act_mem [1024];
    logic signed [DW-1:0] wgt_mem [1024];
    always @(posedge clk) begin
        if (act_rd_en) act_rd_data <= act_mem[act_rd_addr];
        if (wgt_rd_en) wgt_rd_data <= wgt_mem[wgt_rd_addr];
    end

    // MAC model: product register, accumulator, result lagging acc by one enabled cycle.
    // Data registers are intentionally not reset, so stale state must be overwritten.
    logic signed [15:0]   prod_p1 = '0;
    logic signed [AW-1:0] acc_p2  = '0;
    logic signed [AW-1:0] res_p3  = '0;
    logic                 vld_p1 = 1'b0, vld_p2 = 1'b0;
    always @(posedge clk) begin
        if (mac_enable) begin
            prod_p1 <= mac_a * mac_b;
            acc_p2  <= mac_accumulate ? acc_p2 + AW'(prod_p1) : AW'(prod_p1);
            res_p3  <= acc_p2;
        end
        vld_p1 <= mac_enable;
        vld_p2 <= vld_p1;
    end
    assign mac_result = res_p3;
    assign mac_valid  = vld_p2;

    // Monitors on the falling edge
    int              en_cnt = 0;
    logic [RW-1:0]   rd_log [$];
    always @(negedge clk) begin
        if (mac_enable) en_cnt <= en_cnt + 1;
        if (act_rd_en)  rd_log.push_back(act_rd_addr);
    end

    typedef struct {
        longint acc;
        longint q;
    } exp_t;
    exp_t sb [$];

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_total++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint ref_q(input longint a, input int sh, input bit rl);
        longint y;
        y = a >>> sh;
        if (sh > 0) y = y + ((a >> (sh - 1)) & 64'sd1);
        if (rl && y < 0) y = 0;
        if (y > 127) y = 127;
        if (y < -128) y = -128;
        return y;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int g;
        g = 0;
        while (!cmd_ready && g < 100) begin
            step();
            g++;
        end
        if (g >= 100) chk("cmd_ready_timeout", 0, 1);
    endtask

    task automatic run_cmd(input logic [RW-1:0] ab, input logic [RW-1:0] wb, input int n,
                           input int sh, input bit rl, input int hold);
        longint s;
        exp_t   e, p;
        int     lat;
        logic [RW-1:0] aa, wa;
        s = 0;
        for (int i = 0; i < n; i++) begin
            aa = ab + RW'(i);
            wa = wb + RW'(i);
            s  = s + longint'(act_mem[aa]) * longint'(wgt_mem[wa]);
        end
        e.acc = s;
        e.q   = ref_q(s, sh, rl);
        sb.push_back(e);
        wait_ready();
        rd_log.delete();
        en_cnt       = 0;
        cmd_act_base = ab;
        cmd_wgt_base = wb;
        cmd_len      = LW'(n);
        cmd_shift    = 5'(sh);
        cmd_relu     = rl;
        cmd_valid    = 1'b1;
        step();
        cmd_valid = 1'b0;
        lat = 1;
        while (!res_valid && lat < 2000) begin
            step();
            lat++;
        end
        chk("latency", lat, (n == 0) ? 2 : n + 5);
        for (int k = 0; k < hold; k++) begin
            chk("hold_cmd_ready", cmd_ready, 0);
            chk("hold_acc", res_acc, e.acc);
            chk("hold_q", res_q, e.q);
            step();
            chk("hold_valid", res_valid, 1);
        end
        res_ready = 1'b1;
        if (sb.size() == 0) begin
            chk("sb_empty", 0, 1);
        end else begin
            p = sb.pop_front();
            chk("res_acc", res_acc, p.acc);
            chk("res_q", res_q, p.q);
        end
        step();
        res_ready = 1'b0;
        chk("post_valid", res_valid, 0);
        chk("post_cmd_ready", cmd_ready, 1);
        chk("mac_en_cycles", en_cnt, (n == 0) ? 0 : n + 2);
        chk("rd_count", rd_log.size(), n);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            act_mem[i] = DW'($urandom_range(0, 40)) - 8'sd20;
            wgt_mem[i] = DW'($urandom_range(0, 40)) - 8'sd20;
        end
        // Reset state
        #12;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_mac_en", mac_enable, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_acc", res_acc, 0);
        step();
        rst = 1'b0;
        step();

        // N=4 basic dot product
        for (int i = 0; i < 4; i++) begin
            act_mem[i] = DW'(i + 1);
            wgt_mem[i] = DW'(i + 5);
        end
        run_cmd(10'd0, 10'd0, 4, 0, 1'b0, 0);

        // N=1 saturation and shift
        act_mem[10] = -8'sd128;
        wgt_mem[10] = -8'sd128;
        run_cmd(10'd10, 10'd10, 1, 7, 1'b0, 0);
        run_cmd(10'd10, 10'd10, 1, 8, 1'b0, 0);

        // Negative sum: relu clamp, then plain shift
        for (int i = 20; i < 23; i++) begin
            act_mem[i] = -8'sd10;
            wgt_mem[i] = 8'sd10;
        end
        run_cmd(10'd20, 10'd20, 3, 0, 1'b1, 0);
        run_cmd(10'd20, 10'd20, 3, 2, 1'b0, 0);

        // Empty command
        run_cmd(10'd0, 10'd0, 0, 0, 1'b0, 0);

        // Address wrap with result back-pressure
        run_cmd(10'd1022, 10'd500, 4, 1, 1'b0, 5);
        if (rd_log.size() == 4) begin
            chk("wrap_addr0", rd_log[0], 1022);
            chk("wrap_addr1", rd_log[1], 1023);
            chk("wrap_addr2", rd_log[2], 0);
            chk("wrap_addr3", rd_log[3], 1);
        end

        // Random-ish vectors of assorted lengths
        for (int t = 0; t < 3; t++)
            run_cmd(10'(100 + 37 * t), 10'(700 - 29 * t), 5 + 6 * t, t * 3, t[0], t);

        // Reset pulsed mid-RUN of a long command
        wait_ready();
        cmd_act_base = 10'd300;
        cmd_wgt_base = 10'd300;
        cmd_len      = 11'd16;
        cmd_shift    = 5'd0;
        cmd_relu     = 1'b0;
        cmd_valid    = 1'b1;
        step();
        cmd_valid = 1'b0;
        repeat (8) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("mid_rst_cmd_ready", cmd_ready, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_mac_en", mac_enable, 0);
        chk("mid_rst_rd_en", act_rd_en, 0);
        chk("mid_rst_res_valid", res_valid, 0);
        chk("mid_rst_res_acc", res_acc, 0);
        chk("mid_rst_res_q", res_q, 0);
        step();
        rst = 1'b0;
        step();
        act_mem[200] = 8'sd3;
        act_mem[201] = 8'sd4;
        wgt_mem[200] = 8'sd5;
        wgt_mem[201] = 8'sd6;
        run_cmd(10'd200, 10'd200, 2, 0, 1'b0, 0);

        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
